// File: rtl/eightbit_pkg.sv
// Shared types for the interrupt controller.
//   intc_reg_t   : register map on the 4-bit device address (0..7)
//   intc_state_t : grant sequencing states
//   intc_prio_t  : arbitration policy selected by CTRL bit1
//   byte_lane    : pick the LO or HI byte of a channel vector padded to 16 bits
package eightbit_pkg;

    typedef enum logic [3:0] {
        REG_PEND_LO = 4'd0,
        REG_PEND_HI = 4'd1,
        REG_MASK_LO = 4'd2,
        REG_MASK_HI = 4'd3,
        REG_EDGE_LO = 4'd4,
        REG_EDGE_HI = 4'd5,
        REG_VECTOR  = 4'd6,
        REG_CTRL    = 4'd7
    } intc_reg_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        SERVICE  = 2'd2,
        COMPLETE = 2'd3
    } intc_state_t;

    typedef enum logic {
        FIXED       = 1'b0,
        ROUND_ROBIN = 1'b1
    } intc_prio_t;

    // Channel index width; the VECTOR register exposes it in bits [3:0].
    localparam int IDX_W = 4;

    function automatic logic [7:0] byte_lane(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/interrupt_controller_arbiter.sv
// priority_arbiter: combinational one-hot selector.
//   req   : eligible channels
//   ptr   : round-robin start channel (ignored in fixed mode)
//   rr    : 1 = round-robin (search from ptr upward, wrapping), 0 = lowest index wins
//   grant : one-hot winner, zero when nothing requested
//   idx   : binary index of the winner
//   valid : any request present
module priority_arbiter
    import eightbit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int start_idx;
    int cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        valid     = 1'b0;
        start_idx = rr ? int'(ptr) : 0;
        if (start_idx >= WIDTH) begin
            start_idx = 0;
        end
        cand = 0;
        // Walk the channels once starting at start_idx; the first hit wins.
        for (int i = 0; i < WIDTH; i++) begin
            cand = start_idx + i;
            if (cand >= WIDTH) begin
                cand = cand - WIDTH;
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches WIDTH interrupt sources, arbitrates them and
// hands a one-hot grant to the servicing FSM, holding it through service.
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   address        : register select (0..7 implemented, rest read 0)
//   enable, mode   : device select; mode 1 = write, 0 = read
//   data_in        : write data
//   data_out       : registered read data, high-Z unless enable && !mode
//   interrupt_in   : raw sources, synchronous to clk
//   processing     : FSM is servicing the granted interrupt
//   interrupt_out  : one-hot grant, zero when none
module interrupt_controller
    import eightbit_pkg::*;
#(
    parameter int              WIDTH      = 8,
    parameter int              DATA_WIDTH = 8,
    parameter int              ADDR_WIDTH = 4,
    parameter logic [WIDTH-1:0] MASK_RESET = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0]      interrupt_in,
    input  logic                  processing,
    output logic [WIDTH-1:0]      interrupt_out
);

    logic [WIDTH-1:0]      pend_q, mask_q, edge_q, prev_in_q, grant_q;
    logic                  en_q;
    intc_prio_t            prio_q;
    logic [IDX_W-1:0]      rr_ptr_q, gidx_q;
    intc_state_t           state_q, state_d;
    logic [WIDTH-1:0]      grant_d;
    logic [IDX_W-1:0]      gidx_d, rr_ptr_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [3:0]            reg_sel;
    logic                  addr_ok, wr_en, rd_en, granting;
    logic [7:0]            wbyte, rd_byte;
    logic [WIDTH-1:0]      w1c, rise, cclr, eligible, pend_d;
    logic [WIDTH-1:0]      arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;

    // Replace one byte lane of a channel vector, dropping bits above WIDTH.
    function automatic logic [WIDTH-1:0] lane_write(input logic [WIDTH-1:0] cur,
                                                   input logic hi, input logic [7:0] b);
        logic [15:0] v;
        v = 16'(cur);
        if (hi) v[15:8] = b;
        else    v[7:0]  = b;
        return WIDTH'(v);
    endfunction

    assign reg_sel  = 4'(address);
    assign addr_ok  = (32'(address) < 16);
    assign wr_en    = enable && mode && addr_ok;
    assign rd_en    = enable && !mode;
    assign wbyte    = 8'(data_in);
    assign granting = (state_q == GRANT) || (state_q == SERVICE);

    // Pending update: edge channels accumulate rising edges and clear on W1C
    // or on completion, with a new edge taking precedence over either clear;
    // level channels simply follow the input.
    always_comb begin
        w1c = '0;
        if (wr_en && reg_sel == REG_PEND_LO) w1c = lane_write('0, 1'b0, wbyte);
        else if (wr_en && reg_sel == REG_PEND_HI) w1c = lane_write('0, 1'b1, wbyte);
    end

    assign cclr     = (state_q == COMPLETE) ? grant_q : '0;
    assign rise     = interrupt_in & ~prev_in_q;
    assign pend_d   = (edge_q & ((pend_q & ~w1c & ~cclr) | rise)) | (~edge_q & interrupt_in);
    assign eligible = pend_q & mask_q & {WIDTH{en_q}};

    priority_arbiter #(.WIDTH(WIDTH)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .rr    (prio_q == ROUND_ROBIN),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= '0;
            mask_q    <= MASK_RESET;
            edge_q    <= '0;
            prev_in_q <= '0;
            en_q      <= 1'b0;
            prio_q    <= FIXED;
        end else begin
            pend_q    <= pend_d;
            prev_in_q <= interrupt_in;
            if (wr_en) begin
                case (reg_sel)
                    REG_MASK_LO: mask_q <= lane_write(mask_q, 1'b0, wbyte);
                    REG_MASK_HI: mask_q <= lane_write(mask_q, 1'b1, wbyte);
                    REG_EDGE_LO: edge_q <= lane_write(edge_q, 1'b0, wbyte);
                    REG_EDGE_HI: edge_q <= lane_write(edge_q, 1'b1, wbyte);
                    REG_CTRL: begin
                        en_q   <= wbyte[0];
                        prio_q <= intc_prio_t'(wbyte[1]);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Grant sequencing: the grant is captured once on leaving IDLE and is
    // only re-evaluated in GRANT; SERVICE ignores mask/pending changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = GRANT;
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                end
            end
            GRANT: begin
                if (processing) begin
                    state_d = SERVICE;
                end else if ((eligible & grant_q) == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (!processing) state_d = COMPLETE;
            end
            COMPLETE: begin
                state_d  = IDLE;
                rr_ptr_d = (gidx_q == IDX_W'(WIDTH - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign interrupt_out = granting ? grant_q : '0;

    always_comb begin
        rd_byte = '0;
        case (reg_sel)
            REG_PEND_LO: rd_byte = byte_lane(16'(pend_q), 1'b0);
            REG_PEND_HI: rd_byte = byte_lane(16'(pend_q), 1'b1);
            REG_MASK_LO: rd_byte = byte_lane(16'(mask_q), 1'b0);
            REG_MASK_HI: rd_byte = byte_lane(16'(mask_q), 1'b1);
            REG_EDGE_LO: rd_byte = byte_lane(16'(edge_q), 1'b0);
            REG_EDGE_HI: rd_byte = byte_lane(16'(edge_q), 1'b1);
            REG_VECTOR:  rd_byte = granting ? {1'b1, 3'b000, gidx_q} : 8'h00;
            REG_CTRL:    rd_byte = {6'b000000, (prio_q == ROUND_ROBIN), en_q};
            default:     rd_byte = '0;
        endcase
        if (!addr_ok) rd_byte = '0;
    end

    // Read data is registered; the bus is driven only while the read is selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= DATA_WIDTH'(rd_byte);
        end
    end

    assign data_out = rd_en ? rdata_q : 'z;

endmodule
